spi_lcd_sink: RTL and testbench

Receive-side decoder for the 4-wire SPI LCD stream produced by `spi_lcd`, which drives a 132x162 RGB565 panel. It oversamples SCK, MOSI, D/C, CS_n and RST_n on the system clock and reassembles bytes. It decodes the panel commands CASET, RASET, RAMWR and SWRESET, and emits one addressed pixel per RGB565 pair. It sits in loopback and debug builds between the `lcd_*_out` pins and a shadow frame buffer or pixel checker.

---
 rtl/lcd_pkg.sv | 28 ++
 rtl/spi_byte_rx.sv | 73 +++++++
 rtl/spi_lcd_sink.sv | 191 +++++++++++++++++++
 tb/tb_spi_lcd_sink.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// ============================================================================
// Module : lcd_pkg
// Brief  : Shared opcodes, decoder states and panel defaults for spi_lcd_sink.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package lcd_pkg;

    localparam int LCD_W_DEFAULT = 132;
    localparam int LCD_H_DEFAULT = 162;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_RASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    typedef enum logic [2:0] {
        CMD   = 3'd0,
        CASET = 3'd1,
        RASET = 3'd2,
        WR_HI = 3'd3,
        WR_LO = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/spi_byte_rx.sv
// ============================================================================
// Module : spi_byte_rx
// Brief  : Oversampling SPI receiver: synchronizers, SCK edge detect, bytes.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module spi_byte_rx (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lcd_clk_in,
    input  logic       lcd_data_in,
    input  logic       lcd_dc_in,
    input  logic       lcd_cs_n_in,
    input  logic       lcd_rst_n_in,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_dc,
    output logic       panel_rst
);

    // Synchronizer bit order: {rst_n, cs_n, dc, mosi, sck}
    logic [4:0] r_s1;
    logic [4:0] r_s2;
    logic       r_sck_d;
    logic       r_cs_d;
    logic [6:0] r_shift;
    logic [2:0] r_bit_cnt;

    logic w_sck_rise;
    logic w_shift_en;

    assign w_sck_rise = r_s2[0] & ~r_sck_d;
    // An edge coinciding with CS_n rising still counts, so a closing byte completes.
    assign w_shift_en = w_sck_rise & (~r_s2[3] | ~r_cs_d);
    assign panel_rst  = ~r_s2[4];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1       <= '0;
            r_s2       <= '0;
            r_sck_d    <= 1'b0;
            r_cs_d     <= 1'b0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            byte_dc    <= 1'b0;
        end else begin
            r_s1       <= {lcd_rst_n_in, lcd_cs_n_in, lcd_dc_in, lcd_data_in, lcd_clk_in};
            r_s2       <= r_s1;
            r_sck_d    <= r_s2[0];
            r_cs_d     <= r_s2[3];
            byte_valid <= 1'b0;
            if (!r_s2[4]) begin
                r_bit_cnt <= '0;
            end else if (w_shift_en) begin
                r_shift   <= {r_shift[5:0], r_s2[1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    byte_valid <= 1'b1;
                    byte_data  <= {r_shift, r_s2[1]};
                    byte_dc    <= r_s2[2];
                end
            end else if (r_s2[3]) begin
                r_bit_cnt <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/spi_lcd_sink.sv
// ============================================================================
// Module : spi_lcd_sink
// Brief  : Decodes the SPI LCD stream into commands and addressed RGB565 pixels.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module spi_lcd_sink
    import lcd_pkg::*;
#(
    parameter int LCD_W = LCD_W_DEFAULT,
    parameter int LCD_H = LCD_H_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lcd_clk_in,
    input  logic        lcd_data_in,
    input  logic        lcd_dc_in,
    input  logic        lcd_cs_n_in,
    input  logic        lcd_rst_n_in,
    output logic        cmd_valid,
    output logic [7:0]  cmd_byte,
    output logic        pixel_valid,
    output logic [7:0]  pixel_x,
    output logic [7:0]  pixel_y,
    output logic [15:0] pixel_data,
    output logic        frame_done
);

    localparam logic [7:0] c_XE_DEF = 8'(LCD_W - 1);
    localparam logic [7:0] c_YE_DEF = 8'(LCD_H - 1);

    logic       w_bv, w_bdc, w_panel_rst;
    logic [7:0] w_byte;

    spi_byte_rx u_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .lcd_clk_in   (lcd_clk_in),
        .lcd_data_in  (lcd_data_in),
        .lcd_dc_in    (lcd_dc_in),
        .lcd_cs_n_in  (lcd_cs_n_in),
        .lcd_rst_n_in (lcd_rst_n_in),
        .byte_valid   (w_bv),
        .byte_data    (w_byte),
        .byte_dc      (w_bdc),
        .panel_rst    (w_panel_rst)
    );

    state_t     r_state, w_state;
    logic [1:0] r_idx, w_idx;
    logic [7:0] r_p_start, w_p_start;
    logic [7:0] r_xs, r_xe, r_ys, r_ye, w_xs, w_xe, w_ys, w_ye;
    logic [7:0] r_cx, r_cy, w_cx, w_cy;
    logic [7:0] r_hi, w_hi;
    logic       w_cmd_valid, w_pix_valid, w_fd;
    logic [7:0] w_cmd_byte, w_px, w_py;
    logic [15:0] w_pd;

    always_comb begin
        w_state     = r_state;
        w_idx       = r_idx;
        w_p_start   = r_p_start;
        w_xs        = r_xs;
        w_xe        = r_xe;
        w_ys        = r_ys;
        w_ye        = r_ye;
        w_cx        = r_cx;
        w_cy        = r_cy;
        w_hi        = r_hi;
        w_cmd_valid = 1'b0;
        w_cmd_byte  = cmd_byte;
        w_pix_valid = 1'b0;
        w_px        = pixel_x;
        w_py        = pixel_y;
        w_pd        = pixel_data;
        w_fd        = 1'b0;
        if (w_panel_rst) begin
            w_state = CMD;
            w_xs    = 8'd0;
            w_xe    = c_XE_DEF;
            w_ys    = 8'd0;
            w_ye    = c_YE_DEF;
        end else if (w_bv && !w_bdc) begin
            w_cmd_valid = 1'b1;
            w_cmd_byte  = w_byte;
            w_idx       = 2'd0;
            case (w_byte)
                CMD_CASET: w_state = CASET;
                CMD_RASET: w_state = RASET;
                CMD_RAMWR: begin
                    w_cx    = r_xs;
                    w_cy    = r_ys;
                    w_state = WR_HI;
                end
                CMD_SWRESET: begin
                    w_state = CMD;
                    w_xs    = 8'd0;
                    w_xe    = c_XE_DEF;
                    w_ys    = 8'd0;
                    w_ye    = c_YE_DEF;
                end
                default: w_state = CMD;
            endcase
        end else if (w_bv) begin
            case (r_state)
                CASET, RASET: begin
                    // High bytes are ignored; the window only changes on the end-low byte.
                    w_idx = r_idx + 2'd1;
                    if (r_idx == 2'd1) w_p_start = w_byte;
                    if (r_idx == 2'd3) begin
                        w_state = CMD;
                        if (r_state == CASET) begin
                            w_xs = r_p_start;
                            w_xe = w_byte;
                        end else begin
                            w_ys = r_p_start;
                            w_ye = w_byte;
                        end
                    end
                end
                WR_HI: begin
                    w_hi    = w_byte;
                    w_state = WR_LO;
                end
                WR_LO: begin
                    w_pix_valid = 1'b1;
                    w_px        = r_cx;
                    w_py        = r_cy;
                    w_pd        = {r_hi, w_byte};
                    w_state     = WR_HI;
                    if (r_cx == r_xe) begin
                        w_cx = r_xs;
                        if (r_cy == r_ye) begin
                            w_cy = r_ys;
                            w_fd = 1'b1;
                        end else begin
                            w_cy = r_cy + 8'd1;
                        end
                    end else begin
                        w_cx = r_cx + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= CMD;
            r_idx       <= '0;
            r_p_start   <= '0;
            r_xs        <= 8'd0;
            r_xe        <= c_XE_DEF;
            r_ys        <= 8'd0;
            r_ye        <= c_YE_DEF;
            r_cx        <= '0;
            r_cy        <= '0;
            r_hi        <= '0;
            cmd_valid   <= 1'b0;
            cmd_byte    <= '0;
            pixel_valid <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            pixel_data  <= '0;
            frame_done  <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_idx       <= w_idx;
            r_p_start   <= w_p_start;
            r_xs        <= w_xs;
            r_xe        <= w_xe;
            r_ys        <= w_ys;
            r_ye        <= w_ye;
            r_cx        <= w_cx;
            r_cy        <= w_cy;
            r_hi        <= w_hi;
            cmd_valid   <= w_cmd_valid;
            cmd_byte    <= w_cmd_byte;
            pixel_valid <= w_pix_valid;
            pixel_x     <= w_px;
            pixel_y     <= w_py;
            pixel_data  <= w_pd;
            frame_done  <= w_fd;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_lcd_sink.sv
// ============================================================================
// Module : tb_spi_lcd_sink
// Brief  : Directed self-checking bench for spi_lcd_sink (SCK = clk/4).
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_spi_lcd_sink;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sck = 1'b0;
    logic        mosi = 1'b0;
    logic        dc = 1'b0;
    logic        cs_n = 1'b1;
    logic        lrst_n = 1'b1;
    logic        cmd_valid;
    logic [7:0]  cmd_byte;
    logic        pixel_valid;
    logic [7:0]  pixel_x;
    logic [7:0]  pixel_y;
    logic [15:0] pixel_data;
    logic        frame_done;

    spi_lcd_sink dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lcd_clk_in   (sck),
        .lcd_data_in  (mosi),
        .lcd_dc_in    (dc),
        .lcd_cs_n_in  (cs_n),
        .lcd_rst_n_in (lrst_n),
        .cmd_valid    (cmd_valid),
        .cmd_byte     (cmd_byte),
        .pixel_valid  (pixel_valid),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .pixel_data   (pixel_data),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] d;
        logic        fd;
    } pix_t;

    int         cyc = 0;
    int         n_chk = 0;
    int         n_pass = 0;
    int         fd_cnt = 0;
    int         last_edge_cyc = 0;
    pix_t       pq[$];
    logic [7:0] cq[$];
    int         cq_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cmd_valid) begin
            cq.push_back(cmd_byte);
            cq_cyc.push_back(cyc);
        end
        if (pixel_valid) pq.push_back('{pixel_x, pixel_y, pixel_data, frame_done});
        if (frame_done) fd_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_clks(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send_byte(input logic d_c, input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            sck  = 1'b0;
            mosi = b[i];
            dc   = d_c;
            @(negedge clk);
            @(negedge clk);
            sck = 1'b1;
            if (i == 0) last_edge_cyc = cyc;
            @(negedge clk);
        end
        @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic exp_pix(input string tag, input int x, input int y, input int d, input int fd);
        pix_t p;
        chk({tag, " avail"}, 32'(pq.size() > 0), 32'd1);
        if (pq.size() > 0) begin
            p = pq.pop_front();
            chk({tag, " x"}, 32'(p.x), 32'(x));
            chk({tag, " y"}, 32'(p.y), 32'(y));
            chk({tag, " data"}, 32'(p.d), 32'(d));
            chk({tag, " fd"}, 32'(p.fd), 32'(fd));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " cmd_valid"}, 32'(cmd_valid), 32'd0);
        chk({tag, " cmd_byte"}, 32'(cmd_byte), 32'd0);
        chk({tag, " pixel_valid"}, 32'(pixel_valid), 32'd0);
        chk({tag, " pixel_xy"}, {16'd0, pixel_x, pixel_y}, 32'd0);
        chk({tag, " pixel_data"}, 32'(pixel_data), 32'd0);
        chk({tag, " frame_done"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int e1;
        int bad;
        pix_t p;

        wait_clks(5);
        chk_all_zero("reset");
        rst_n = 1'b1;
        cs_n  = 1'b0;
        wait_clks(6);
        chk_all_zero("idle");

        // Basic RAMWR on the default window, plus command latency.
        send_byte(1'b0, 8'h2C);
        e1 = last_edge_cyc;
        send_byte(1'b1, 8'hF8); send_byte(1'b1, 8'h00);
        send_byte(1'b1, 8'h07); send_byte(1'b1, 8'hE0);
        wait_clks(10);
        chk("t1 cmd count", 32'(cq.size()), 32'd1);
        if (cq.size() > 0) begin
            chk("t1 cmd byte", 32'(cq[0]), 32'h2C);
            chk("t1 cmd latency", 32'(cq_cyc[0] - e1), 32'd4);
        end
        exp_pix("t1 p0", 0, 0, 16'hF800, 0);
        exp_pix("t1 p1", 1, 0, 16'h07E0, 0);
        cq.delete(); cq_cyc.delete();

        // 2x2 window with frame wrap.
        fd_cnt = 0;
        send_byte(1'b0, 8'h2A);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h0A); send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h0B);
        send_byte(1'b0, 8'h2B);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h05); send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h06);
        send_byte(1'b0, 8'h2C);
        for (int k = 0; k < 5; k++) begin
            send_byte(1'b1, 8'h10);
            send_byte(1'b1, 8'(k));
        end
        wait_clks(10);
        chk("t2 cmd count", 32'(cq.size()), 32'd3);
        exp_pix("t2 p0", 10, 5, 16'h1000, 0);
        exp_pix("t2 p1", 11, 5, 16'h1001, 0);
        exp_pix("t2 p2", 10, 6, 16'h1002, 0);
        exp_pix("t2 p3", 11, 6, 16'h1003, 1);
        exp_pix("t2 p4", 10, 5, 16'h1004, 0);
        chk("t2 fd count", 32'(fd_cnt), 32'd1);
        cq.delete(); cq_cyc.delete();

        // SWRESET, then a truncated CASET must not move the window.
        send_byte(1'b0, 8'h01);
        send_byte(1'b0, 8'h2A);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h0A);
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'hAB); send_byte(1'b1, 8'hCD);
        wait_clks(10);
        exp_pix("t3 p0", 0, 0, 16'hABCD, 0);
        cq.delete(); cq_cyc.delete();

        // Partial byte dropped by CS_n deassertion.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); sck = 1'b0; mosi = 1'b1; dc = 1'b0;
            @(negedge clk);
            @(negedge clk); sck = 1'b1;
            @(negedge clk);
        end
        @(negedge clk); sck = 1'b0;
        wait_clks(3);
        cs_n = 1'b1;
        wait_clks(8);
        cs_n = 1'b0;
        wait_clks(4);
        send_byte(1'b0, 8'h2C);
        wait_clks(10);
        chk("t4 cmd count", 32'(cq.size()), 32'd1);
        if (cq.size() > 0) chk("t4 cmd byte", 32'(cq[0]), 32'h2C);
        cq.delete(); cq_cyc.delete();

        // Panel reset mid-pixel returns the decoder to CMD.
        send_byte(1'b1, 8'h12);
        @(negedge clk); lrst_n = 1'b0;
        wait_clks(10);
        lrst_n = 1'b1;
        wait_clks(4);
        send_byte(1'b1, 8'h34); send_byte(1'b1, 8'h56);
        wait_clks(10);
        chk("t5 no pixel", 32'(pq.size()), 32'd0);

        // System reset mid-RAMWR clears every output.
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'h77); send_byte(1'b1, 8'h88);
        send_byte(1'b1, 8'h99);
        wait_clks(6);
        rst_n = 1'b0;
        wait_clks(5);
        chk_all_zero("t6 in reset");
        wait_clks(5);
        rst_n = 1'b1;
        wait_clks(4);
        send_byte(1'b1, 8'h34); send_byte(1'b1, 8'h56);
        wait_clks(10);
        exp_pix("t6 pre", 0, 0, 16'h7788, 0);
        chk("t6 no pixel after", 32'(pq.size()), 32'd0);
        cq.delete(); cq_cyc.delete();

        // Last two panel rows at full width: x and y wrap at the panel edge.
        fd_cnt = 0;
        send_byte(1'b0, 8'h2B);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'hA0); send_byte(1'b1, 8'h00); send_byte(1'b1, 8'hA1);
        send_byte(1'b0, 8'h2C);
        for (int k = 0; k < 265; k++) begin
            send_byte(1'b1, 8'(k >> 8));
            send_byte(1'b1, 8'(k));
        end
        wait_clks(10);
        chk("t7 pixel count", 32'(pq.size()), 32'd265);
        chk("t7 fd count", 32'(fd_cnt), 32'd1);
        bad = 0;
        for (int k = 0; k < 264 && pq.size() > 0; k++) begin
            p = pq.pop_front();
            if (p.x != 8'(k % 132) || p.y != 8'(160 + k / 132) ||
                p.d != 16'(k) || p.fd != (k == 263)) begin
                bad++;
                if (k == 263) chk("t7 last xy", {16'd0, p.x, p.y}, {16'd0, 8'd131, 8'd161});
            end
        end
        chk("t7 sequence errors", 32'(bad), 32'd0);
        exp_pix("t7 wrap", 0, 160, 16'd264, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
